// File: rtl/axil_arb_pkg.sv
// Shared types and default widths for the axilite backend arbiter.
//   state_t     : sequencer states
//   DEF_*       : default parameter values used by the arbiter modules
package axil_arb_pkg;

   localparam int unsigned DEF_NUM_REQ = 4;
   localparam int unsigned DEF_ADDR_W  = 12;
   localparam int unsigned DEF_DATA_W  = 32;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      ISSUE     = 2'd1,
      WAIT_DONE = 2'd2,
      RESP      = 2'd3
   } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin selector: first set request at or above ptr,
// wrapping past NUM_REQ-1 back to 0.
//   req   : request vector
//   ptr   : highest-priority index
//   grant : one-hot winner (all zero when req is empty)
//   idx   : encoded winner index
module rr_arbiter
   import axil_arb_pkg::*;
#(
   parameter int unsigned NUM_REQ = DEF_NUM_REQ,
   parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   ptr,
   output logic [NUM_REQ-1:0] grant,
   output logic [IDX_W-1:0]   idx
);

   // Scan NUM_REQ positions starting at ptr; the first hit wins.
   always_comb begin
      int unsigned pos;
      logic        found;
      logic [IDX_W-1:0] p;
      grant = '0;
      idx   = '0;
      found = 1'b0;
      pos   = 0;
      p     = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         pos = 32'(ptr) + i;
         if (pos >= NUM_REQ) pos = pos - NUM_REQ;
         p = IDX_W'(pos);
         if (!found && req[p]) begin
            found    = 1'b1;
            grant[p] = 1'b1;
            idx      = p;
         end
      end
   end

endmodule

// File: rtl/axilite_bk_arbiter.sv
// Round-robin arbiter/sequencer sharing one axilite master backend among
// NUM_REQ requesters, one transaction in flight at a time.
//   axi_aclk, axi_aresetn         : clock, async active-low reset
//   req_valid/write/addr/wdata/wstrb : packed per-requester requests
//   req_ready, rsp_valid          : one-hot accept / completion pulses
//   rsp_rdata                     : last captured read data
//   busy                          : transaction in flight
//   bk_w*/bk_r*                   : backend command outputs
//   bk_wdone, bk_rdone, bk_rdata  : backend completion inputs
module axilite_bk_arbiter
   import axil_arb_pkg::*;
#(
   parameter int unsigned NUM_REQ = DEF_NUM_REQ,
   parameter int unsigned ADDR_W  = DEF_ADDR_W,
   parameter int unsigned DATA_W  = DEF_DATA_W
) (
   input  logic                          axi_aclk,
   input  logic                          axi_aresetn,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ-1:0]            req_write,
   input  logic [NUM_REQ*ADDR_W-1:0]     req_addr,
   input  logic [NUM_REQ*DATA_W-1:0]     req_wdata,
   input  logic [NUM_REQ*(DATA_W/8)-1:0] req_wstrb,
   output logic [NUM_REQ-1:0]            req_ready,
   output logic [NUM_REQ-1:0]            rsp_valid,
   output logic [DATA_W-1:0]             rsp_rdata,
   output logic                          busy,
   output logic                          bk_wstart,
   output logic [ADDR_W-1:0]             bk_waddr,
   output logic [DATA_W-1:0]             bk_wdata,
   output logic [DATA_W/8-1:0]           bk_wstrb,
   output logic                          bk_rstart,
   output logic [ADDR_W-1:0]             bk_raddr,
   input  logic                          bk_wdone,
   input  logic                          bk_rdone,
   input  logic [DATA_W-1:0]             bk_rdata
);

   localparam int unsigned STRB_W = DATA_W / 8;
   localparam int unsigned IDX_W  = $clog2(NUM_REQ);

   state_t              state_q, state_n;
   logic [IDX_W-1:0]    ptr_q, ptr_n;
   logic [IDX_W-1:0]    g_q, g_n;
   logic                wr_q, wr_n;
   logic [ADDR_W-1:0]   addr_q, addr_n;
   logic [DATA_W-1:0]   wdata_q, wdata_n;
   logic [STRB_W-1:0]   wstrb_q, wstrb_n;

   logic [NUM_REQ-1:0]  req_ready_n, rsp_valid_n;
   logic [DATA_W-1:0]   rsp_rdata_n;
   logic                busy_n, bk_wstart_n, bk_rstart_n;
   logic [ADDR_W-1:0]   bk_waddr_n, bk_raddr_n;
   logic [DATA_W-1:0]   bk_wdata_n;
   logic [STRB_W-1:0]   bk_wstrb_n;

   logic [NUM_REQ-1:0]  grant;
   logic [IDX_W-1:0]    grant_idx;
   logic [ADDR_W-1:0]   sel_addr;
   logic [DATA_W-1:0]   sel_wdata;
   logic [STRB_W-1:0]   sel_wstrb;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_rr (
      .req   (req_valid),
      .ptr   (ptr_q),
      .grant (grant),
      .idx   (grant_idx)
   );

   // Winner payload mux (one-hot OR).
   always_comb begin
      sel_addr  = '0;
      sel_wdata = '0;
      sel_wstrb = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (grant[i]) begin
            sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
            sel_wdata = req_wdata[i*DATA_W +: DATA_W];
            sel_wstrb = req_wstrb[i*STRB_W +: STRB_W];
         end
      end
   end

   // Next state; outputs are computed for the state being entered so the
   // registered copies line up with that state's cycle.
   always_comb begin
      state_n     = state_q;
      ptr_n       = ptr_q;
      g_n         = g_q;
      wr_n        = wr_q;
      addr_n      = addr_q;
      wdata_n     = wdata_q;
      wstrb_n     = wstrb_q;
      req_ready_n = '0;
      rsp_valid_n = '0;
      rsp_rdata_n = rsp_rdata;
      bk_wstart_n = 1'b0;
      bk_waddr_n  = '0;
      bk_wdata_n  = '0;
      bk_wstrb_n  = '0;
      bk_rstart_n = 1'b0;
      bk_raddr_n  = '0;

      unique case (state_q)
         IDLE: begin
            if (|req_valid) begin
               g_n         = grant_idx;
               wr_n        = req_write[grant_idx];
               addr_n      = sel_addr;
               wdata_n     = sel_wdata;
               wstrb_n     = sel_wstrb;
               req_ready_n = grant;
               if (wr_n) begin
                  bk_wstart_n = 1'b1;
                  bk_waddr_n  = sel_addr;
                  bk_wdata_n  = sel_wdata;
                  bk_wstrb_n  = sel_wstrb;
               end else begin
                  bk_rstart_n = 1'b1;
                  bk_raddr_n  = sel_addr;
               end
               state_n = ISSUE;
            end
         end
         ISSUE: begin
            ptr_n   = (g_q == IDX_W'(NUM_REQ - 1)) ? '0 : g_q + IDX_W'(1);
            state_n = WAIT_DONE;
         end
         WAIT_DONE: begin
            // Only the done matching the latched direction completes.
            if (wr_q ? bk_wdone : bk_rdone) begin
               rsp_valid_n = NUM_REQ'(1) << g_q;
               if (!wr_q) rsp_rdata_n = bk_rdata;
               state_n = RESP;
            end
         end
         RESP: begin
            state_n = IDLE;
         end
         default: begin
            state_n = IDLE;
         end
      endcase

      busy_n = (state_n != IDLE);
   end

   // State and output registers.
   always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
      if (!axi_aresetn) begin
         state_q   <= IDLE;
         ptr_q     <= '0;
         g_q       <= '0;
         wr_q      <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
         req_ready <= '0;
         rsp_valid <= '0;
         rsp_rdata <= '0;
         busy      <= 1'b0;
         bk_wstart <= 1'b0;
         bk_waddr  <= '0;
         bk_wdata  <= '0;
         bk_wstrb  <= '0;
         bk_rstart <= 1'b0;
         bk_raddr  <= '0;
      end else begin
         state_q   <= state_n;
         ptr_q     <= ptr_n;
         g_q       <= g_n;
         wr_q      <= wr_n;
         addr_q    <= addr_n;
         wdata_q   <= wdata_n;
         wstrb_q   <= wstrb_n;
         req_ready <= req_ready_n;
         rsp_valid <= rsp_valid_n;
         rsp_rdata <= rsp_rdata_n;
         busy      <= busy_n;
         bk_wstart <= bk_wstart_n;
         bk_waddr  <= bk_waddr_n;
         bk_wdata  <= bk_wdata_n;
         bk_wstrb  <= bk_wstrb_n;
         bk_rstart <= bk_rstart_n;
         bk_raddr  <= bk_raddr_n;
      end
   end

endmodule

// File: doc/axilite_bk_arbiter.md
Name: axilite_bk_arbiter

Overview:
Round-robin arbiter and sequencer that shares one axilite master backend port among NUM_REQ requesters (config CPU shim, DMA descriptor loader, debug bridge, etc.). Each requester issues single read or write requests with a valid/ready handshake and receives a single-cycle response pulse. Only one transaction is outstanding at a time. The block sits directly in front of the axilite master backend inputs.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ADDR_W, 12, backend address width
DATA_W, 32, data width; strobe width is DATA_W/8

Ports:
axi_aclk  in  1  clock
axi_aresetn  in  1  asynchronous active-low reset
req_valid  in  NUM_REQ  per-requester request valid
req_write  in  NUM_REQ  1 = write, 0 = read
req_addr  in  NUM_REQ*ADDR_W  packed addresses; requester i occupies slice [i*ADDR_W +: ADDR_W]
req_wdata  in  NUM_REQ*DATA_W  packed write data
req_wstrb  in  NUM_REQ*DATA_W/8  packed write strobes
req_ready  out  NUM_REQ  one-hot accept pulse
rsp_valid  out  NUM_REQ  one-hot completion pulse
rsp_rdata  out  DATA_W  read data; valid with rsp_valid of a read
busy  out  1  transaction in flight (state != IDLE)
bk_wstart, bk_waddr, bk_wdata, bk_wstrb  out  1/ADDR_W/DATA_W/DATA_W/8  backend write command
bk_rstart, bk_raddr  out  1/ADDR_W  backend read command
bk_wdone, bk_rdone  in  1  backend single-cycle completion pulses
bk_rdata  in  DATA_W  backend read data; valid when bk_rdone=1

Behaviour:
- Reset (axi_aresetn, asynchronous, active-low; clock axi_aclk):
  - state=IDLE, rr pointer=0.
  - All outputs 0, including rsp_rdata and all bk_* command fields.
- Registered FSM, states IDLE, ISSUE, WAIT_DONE, RESP:
  - IDLE: if any req_valid, select winner g = first set bit scanning from the pointer upward, with wrap-around. Latch g, req_write[g], and g's addr/wdata/wstrb. Go to ISSUE. Otherwise stay in IDLE.
  - ISSUE (exactly 1 cycle):
    - req_ready[g]=1.
    - Write: bk_wstart=1. Read: bk_rstart=1.
    - The command fields carry the latched values. Only the active start bit is 1.
    - pointer <= (g+1) mod NUM_REQ. Go to WAIT_DONE.
  - WAIT_DONE:
    - Write: wait for bk_wdone. Read: wait for bk_rdone; on it, capture bk_rdata into rsp_rdata.
    - A done of the wrong type is ignored.
    - No timeout. Stays indefinitely until the matching done.
  - RESP (1 cycle): rsp_valid[g]=1, then go to IDLE.
- Latency: req_valid rising in IDLE at cycle 0 -> req_ready and bk_*start at cycle 1.
- Response timing: bk_*done at cycle k -> rsp_valid at cycle k+1 -> next grant possible at cycle k+3.
- Requester rules:
  - Must hold valid and payload stable until req_ready.
  - May drop req_valid before a grant (withdrawal, no effect).
  - Must accept rsp_valid (no backpressure).
- The latched payload is used; input changes after the IDLE sampling cycle are ignored.
- bk_waddr/bk_wdata/bk_wstrb/bk_raddr:
  - Driven from the latch only in ISSUE, zero otherwise.
  - The unused direction's fields are zero.
- rsp_rdata: holds its value until the next read capture. Unchanged on writes.
- busy=1 in ISSUE, WAIT_DONE and RESP.
- Boundaries:
  - All requesters valid: grants strictly rotate 0,1,2,3,0...
  - Pointer wrap: g=NUM_REQ-1 gives pointer 0.
  - bk_*done in IDLE/ISSUE/RESP: ignored.
  - Reset mid-transaction: FSM abandons; no rsp_valid is issued.

Decomposition:
- Package axil_arb_pkg: state enum (IDLE, ISSUE, WAIT_DONE, RESP) and default width constants.
- Sub-module rr_arbiter:
  - Inputs: req vector, pointer. Output: one-hot grant plus encoded index.
  - Purely combinational, parameterized by NUM_REQ, instantiated once.

Test Plan:
- Single write: req0 valid, write, addr 0x010, wdata 0xA5A5_0001, wstrb 0xF. Backend returns bk_wdone 3 cycles after bk_wstart.
  -> req_ready[0] at cycle 1; bk_wstart with exact fields; rsp_valid[0] one cycle after done.
- Single read: req2 read addr 0x3FC, bk_rdata 0x1234_5678 with bk_rdone.
  -> rsp_valid[2] and rsp_rdata=0x1234_5678; bk_rstart=1 and bk_wstart=0 throughout.
- Fairness: all 4 requesters continuously valid, 8 transactions.
  -> grant order 0,1,2,3,0,1,2,3; never two bits set in req_ready or rsp_valid.
- Payload stability: req1 changes addr 0x020->0x040 in the cycle after IDLE sampling.
  -> bk_waddr=0x020.
- Wrong-type done: write in flight, inject bk_rdone.
  -> stays in WAIT_DONE, no rsp_valid; completes on a later bk_wdone.
- Reset mid-operation: assert axi_aresetn=0 in WAIT_DONE.
  -> all outputs 0 immediately, busy=0; after release, first grant goes to the lowest-index valid requester.
